pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 126 ++++++++++++
 tb/tb_pc_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch stage: drives the instruction memory from a fetch PC and
// delivers one instruction per cycle, parking a response in a skid buffer on stall.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        if_valid,
    output logic        addr_err,
    output logic [15:0] fetch_count
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 16;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc, pc_d;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]   pc_out_d, instr_d;
    logic              valid_d, err_d;
    logic [CW-1:0]     cnt_d;

    assign pc_inc    = pc + XLEN'(4);
    assign imem_addr = pc;

    // Next-state and next-output decode; redirect overrides everything else.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        pc_out_d     = PC;
        instr_d      = Instr;
        valid_d      = if_valid;
        err_d        = addr_err;
        cnt_d        = fetch_count;

        if (redirect_valid) begin
            state_d      = FETCH;
            pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
            skid_instr_d = '0;
            skid_pc_d    = '0;
            pc_out_d     = '0;
            instr_d      = '0;
            valid_d      = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready && !stall) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_inc;
                        valid_d  = 1'b1;
                        pc_d     = pc_inc;
                        cnt_d    = fetch_count + CW'(1);
                    end else if (imem_ready && stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_inc;
                        pc_d         = pc_inc;
                        state_d      = HOLD;
                    end else if (!stall) begin
                        instr_d  = '0;
                        pc_out_d = '0;
                        valid_d  = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d  = skid_instr_q;
                        pc_out_d = skid_pc_q;
                        valid_d  = 1'b1;
                        cnt_d    = fetch_count + CW'(1);
                        state_d  = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State, fetch PC, skid buffer and delivered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            pc           <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            PC           <= '0;
            Instr        <= '0;
            if_valid     <= 1'b0;
            addr_err     <= 1'b0;
            fetch_count  <= '0;
            imem_req     <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc           <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            PC           <= pc_out_d;
            Instr        <= instr_d;
            if_valid     <= valid_d;
            addr_err     <= err_d;
            fetch_count  <= cnt_d;
            imem_req     <= (state_d == FETCH);
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        if_valid;
    logic        addr_err;
    logic [15:0] fetch_count;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .PC(PC), .Instr(Instr), .if_valid(if_valid),
        .addr_err(addr_err), .fetch_count(fetch_count)
    );

    // Memory image: every word holds its own address.
    assign imem_rdata = imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetched-but-undelivered instructions sit in a queue.
    logic [31:0] m_pc, m_out_pc, m_instr;
    logic [15:0] m_cnt;
    bit          m_valid, m_err;
    logic [31:0] pend_instr[$];
    logic [31:0] pend_pc[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 32'h3000; m_out_pc = 0; m_instr = 0; m_cnt = 0;
            m_valid = 0; m_err = 0;
            pend_instr.delete(); pend_pc.delete();
        end else if (redirect_valid) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            m_out_pc = 0; m_instr = 0; m_valid = 0;
            if (redirect_pc % 4 != 0) m_err = 1;
            pend_instr.delete(); pend_pc.delete();
        end else if (pend_instr.size() > 0) begin
            if (!stall) begin
                m_instr = pend_instr.pop_front();
                m_out_pc = pend_pc.pop_front();
                m_valid = 1; m_cnt = m_cnt + 1;
            end
        end else if (imem_ready) begin
            if (stall) begin
                pend_instr.push_back(m_pc);
                pend_pc.push_back(m_pc + 4);
            end else begin
                m_instr = m_pc; m_out_pc = m_pc + 4;
                m_valid = 1; m_cnt = m_cnt + 1;
            end
            m_pc = m_pc + 4;
        end else if (!stall) begin
            m_instr = 0; m_out_pc = 0; m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("imem_req", 32'(imem_req), 32'(pend_instr.size() == 0));
            chk("imem_addr", imem_addr, m_pc);
            chk("PC", PC, m_out_pc);
            chk("Instr", Instr, m_instr);
            chk("if_valid", 32'(if_valid), 32'(m_valid));
            chk("addr_err", 32'(addr_err), 32'(m_err));
            chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
        end
    end

    task automatic drive(input bit s, input bit r, input bit rv, input logic [31:0] rpc);
        stall = s; imem_ready = r; redirect_valid = rv; redirect_pc = rpc;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; stall = 0; imem_ready = 0; redirect_valid = 0; redirect_pc = 0;
        repeat (3) @(negedge clk);
        check_en = 1;
        chk("reset_Instr", Instr, 32'h0);
        chk("reset_count", 32'(fetch_count), 32'h0);
        rst = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h3000);

        // Streaming fetch
        drive(0, 1, 0, 0);
        chk("stream0_Instr", Instr, 32'h3000);
        chk("stream0_PC", PC, 32'h3004);
        chk("stream0_cnt", 32'(fetch_count), 32'h1);
        drive(0, 1, 0, 0);
        chk("stream1_Instr", Instr, 32'h3004);
        chk("stream1_cnt", 32'(fetch_count), 32'h2);

        // Stall for three cycles at pc 0x3008
        drive(1, 1, 0, 0);
        chk("stall1_Instr", Instr, 32'h3004);
        chk("stall1_req", 32'(imem_req), 32'h0);
        drive(1, 1, 0, 0);
        chk("stall2_req", 32'(imem_req), 32'h0);
        drive(1, 1, 0, 0);
        chk("stall3_Instr", Instr, 32'h3004);
        drive(0, 1, 0, 0);
        chk("release_Instr", Instr, 32'h3008);
        chk("release_PC", PC, 32'h300C);
        chk("release_addr", imem_addr, 32'h300C);
        chk("release_req", 32'(imem_req), 32'h1);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("pre_bubble_Instr", Instr, 32'h3010);

        // Two memory wait states
        drive(0, 0, 0, 0);
        chk("bubble1_valid", 32'(if_valid), 32'h0);
        chk("bubble1_Instr", Instr, 32'h0);
        chk("bubble1_addr", imem_addr, 32'h3014);
        drive(0, 0, 0, 0);
        chk("bubble2_valid", 32'(if_valid), 32'h0);
        chk("bubble2_addr", imem_addr, 32'h3014);
        drive(0, 1, 0, 0);
        chk("after_bubble_Instr", Instr, 32'h3014);

        // Redirect wins over stall and a same-cycle response
        drive(1, 1, 1, 32'h4000);
        chk("redir_valid", 32'(if_valid), 32'h0);
        chk("redir_Instr", Instr, 32'h0);
        chk("redir_addr", imem_addr, 32'h4000);
        chk("redir_cnt", 32'(fetch_count), 32'd6);
        drive(0, 1, 0, 0);
        chk("redir_first", Instr, 32'h4000);
        drive(1, 1, 0, 0);
        drive(1, 0, 1, 32'h5000);
        chk("redir_hold_addr", imem_addr, 32'h5000);
        chk("redir_hold_req", 32'(imem_req), 32'h1);
        drive(0, 1, 0, 0);
        chk("redir_hold_Instr", Instr, 32'h5000);

        // Mixed stall/ready pattern, checked by the model
        for (int i = 0; i < 24; i++) begin
            drive(bit'((i % 3) == 1), bit'((i % 5) != 2), 0, 0);
        end

        // PC wrap at the top of the address space
        drive(0, 1, 1, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0);
        chk("wrap_Instr", Instr, 32'hFFFF_FFFC);
        chk("wrap_PC", PC, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Misaligned redirect sets a sticky error
        drive(0, 0, 1, 32'h4002);
        chk("misal_addr", imem_addr, 32'h4000);
        chk("misal_err", 32'(addr_err), 32'h1);
        for (int i = 0; i < 100; i++) begin
            drive(bit'((i % 4) == 3), bit'((i % 7) != 0), 0, 0);
        end
        chk("misal_err_sticky", 32'(addr_err), 32'h1);

        // Asynchronous reset while holding a buffered instruction
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_Instr", Instr, 32'h0);
        chk("async_PC", PC, 32'h0);
        chk("async_valid", 32'(if_valid), 32'h0);
        chk("async_err", 32'(addr_err), 32'h0);
        chk("async_cnt", 32'(fetch_count), 32'h0);
        chk("async_addr", imem_addr, 32'h3000);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 0, 0);
        chk("restart_Instr", Instr, 32'h3000);
        chk("restart_cnt", 32'(fetch_count), 32'h1);
        drive(0, 1, 0, 0);

        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
